// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment driver/decoder pair:
// active-low segment patterns, decoded codes, digit selects and FSM states.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    localparam logic [3:0] DIG0 = 4'b1110;
    localparam logic [3:0] DIG1 = 4'b1101;
    localparam logic [3:0] DIG2 = 4'b1011;
    localparam logic [3:0] DIG3 = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to 4-bit code decoder.
// Unknown patterns map to CODE_BAD and raise o_bad.
module seg7_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_code,
    output logic       o_bad
);

    logic [3:0] w_code;

    always_comb begin
        w_code = CODE_BAD;
        unique case (i_pattern)
            SEG_0:     w_code = 4'h0;
            SEG_1:     w_code = 4'h1;
            SEG_2:     w_code = 4'h2;
            SEG_3:     w_code = 4'h3;
            SEG_4:     w_code = 4'h4;
            SEG_5:     w_code = 4'h5;
            SEG_6:     w_code = 4'h6;
            SEG_7:     w_code = 4'h7;
            SEG_8:     w_code = 4'h8;
            SEG_9:     w_code = 4'h9;
            SEG_DASH:  w_code = CODE_DASH;
            SEG_BLANK: w_code = CODE_BLANK;
            default:   w_code = CODE_BAD;
        endcase
    end

    // No legal pattern decodes to CODE_BAD, so the code doubles as the flag
    assign o_code = w_code;
    assign o_bad  = (w_code == CODE_BAD);

endmodule

// File: rtl/seven_segment_decoder.sv
// Samples the multiplexed display/digit bus, decodes each settled digit
// and publishes the 16-bit word once all four positions are captured.
module seven_segment_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int STALE_LIMIT   = 262144
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  display,
    input  logic [3:0]  digit,
    output logic [15:0] nums,
    output logic        valid,
    output logic        frame_done,
    output logic        err
);

    localparam int TW = $clog2(STALE_LIMIT + 1);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] STALE_MAX   = TW'(STALE_LIMIT);
    localparam logic [TW-1:0] STALE_PRE   = TW'(STALE_LIMIT - 1);

    logic [6:0]    r_disp_s1, r_disp_s2, r_disp_prev;
    logic [3:0]    r_dig_s1, r_dig_s2, r_dig_prev;
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_settle_cnt, w_cnt_nxt;
    logic [3:0]    r_seen;
    logic [15:0]   r_shadow;
    logic [15:0]   r_nums;
    logic          r_valid, r_frame_done, r_err;
    logic [TW-1:0] r_stale_cnt;

    logic          w_changed, w_dig_ok, w_sample, w_frame, w_bad;
    logic [1:0]    w_slot;
    logic [3:0]    w_code, w_seen_set;
    logic [15:0]   w_shadow_nxt;

    seg7_pattern_decode u_decode (
        .i_pattern (r_disp_s2),
        .o_code    (w_code),
        .o_bad     (w_bad)
    );

    // Idle bus value is blank / no digit, so synchronisers reset to ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_s1   <= '1;
            r_disp_s2   <= '1;
            r_disp_prev <= '1;
            r_dig_s1    <= '1;
            r_dig_s2    <= '1;
            r_dig_prev  <= '1;
        end else begin
            r_disp_s1   <= display;
            r_disp_s2   <= r_disp_s1;
            r_disp_prev <= r_disp_s2;
            r_dig_s1    <= digit;
            r_dig_s2    <= r_dig_s1;
            r_dig_prev  <= r_dig_s2;
        end
    end

    assign w_changed = (r_disp_s2 != r_disp_prev) || (r_dig_s2 != r_dig_prev);

    always_comb begin
        w_dig_ok = 1'b1;
        w_slot   = 2'd0;
        unique case (r_dig_s2)
            DIG0:    w_slot = 2'd0;
            DIG1:    w_slot = 2'd1;
            DIG2:    w_slot = 2'd2;
            DIG3:    w_slot = 2'd3;
            default: w_dig_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_settle_cnt;
        w_sample    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_dig_ok) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (w_changed) begin
                    w_cnt_nxt = '0;
                    if (!w_dig_ok) w_state_nxt = ST_IDLE;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_settle_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_changed) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_dig_ok ? ST_SETTLE : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[{w_slot, 2'b00} +: 4] = w_code;
    end

    assign w_seen_set = r_seen | (4'b0001 << w_slot);
    assign w_frame    = w_sample && (w_seen_set == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_seen       <= '0;
            r_err        <= 1'b0;
            r_nums       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame;
            if (w_sample) begin
                r_shadow <= w_shadow_nxt;
                r_seen   <= w_frame ? 4'h0 : w_seen_set;
                if (w_bad) r_err <= 1'b1;
            end
            if (w_frame) r_nums <= w_shadow_nxt;
        end
    end

    // A completing frame takes priority over expiry in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stale_cnt <= '0;
            r_valid     <= 1'b0;
        end else if (w_frame) begin
            r_stale_cnt <= '0;
            r_valid     <= 1'b1;
        end else if (r_stale_cnt != STALE_MAX) begin
            r_stale_cnt <= r_stale_cnt + 1'b1;
            if (r_stale_cnt == STALE_PRE) r_valid <= 1'b0;
        end
    end

    assign nums       = r_nums;
    assign valid      = r_valid;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench: expected frames are queued as scans are driven and
// compared against nums on every frame_done pulse.
module tb_seven_segment_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  display;
    logic [3:0]  digit;
    logic [15:0] nums;
    logic        valid;
    logic        frame_done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    int n_frames = 0;
    logic [15:0] sb_q[$];

    seven_segment_decoder #(
        .SETTLE_CYCLES (4),
        .STALE_LIMIT   (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .display    (display),
        .digit      (digit),
        .nums       (nums),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] dsel(input int i);
        case (i)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic hold(input logic [3:0] d, input logic [6:0] p,
                        input int n);
        digit   = d;
        display = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] v);
        sb_q.push_back(v);
        for (int i = 0; i < 4; i++)
            hold(dsel(i), enc(v[i*4 +: 4]), 16);
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            n_frames++;
            if (sb_q.size() == 0)
                chk("frame_unexpected", 32'd1, 32'd0);
            else
                chk("frame_nums", {16'h0, nums}, {16'h0, sb_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        rst_n   = 1'b0;
        display = 7'h7F;
        digit   = 4'hF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_nums", {16'h0, nums}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_fd", {31'h0, frame_done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        repeat (4) @(negedge clk);

        base = n_frames;
        scan(16'h1234);
        hold(4'hF, 7'h7F, 8);
        chk("t1_frames", n_frames, base + 1);
        chk("t1_nums", {16'h0, nums}, 32'h1234);
        chk("t1_valid", {31'h0, valid}, 32'h1);
        chk("t1_err", {31'h0, err}, 32'h0);

        scan(16'h09BA);
        hold(4'hF, 7'h7F, 8);
        chk("t2_nums", {16'h0, nums}, 32'h09BA);

        base = n_frames;
        sb_q.push_back(16'h3574);
        hold(dsel(0), enc(4'h4), 16);
        hold(dsel(2), enc(4'h5), 16);
        hold(dsel(3), enc(4'h3), 16);
        for (int k = 0; k < 8; k++)
            hold(dsel(1), enc((k % 2 == 0) ? 4'h1 : 4'h2), 3);
        chk("t3_no_sample", n_frames, base);
        hold(dsel(1), enc(4'h7), 16);
        hold(4'hF, 7'h7F, 8);
        chk("t3_frames", n_frames, base + 1);
        chk("t3_nib1", {28'h0, nums[7:4]}, 32'h7);

        sb_q.push_back(16'h4F21);
        hold(dsel(0), enc(4'h1), 16);
        hold(dsel(1), enc(4'h2), 16);
        hold(dsel(2), 7'b0101010, 16);
        chk("t4_err_now", {31'h0, err}, 32'h1);
        hold(dsel(3), enc(4'h4), 16);
        hold(4'hF, 7'h7F, 8);
        chk("t4_nib2", {28'h0, nums[11:8]}, 32'hF);

        sb_q.push_back(16'h8642);
        hold(dsel(0), enc(4'h2), 16);
        hold(dsel(1), enc(4'h4), 16);
        hold(dsel(2), enc(4'h6), 16);
        digit   = dsel(3);
        display = enc(4'h8);
        t = 0;
        while (!frame_done && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("t5_fd_seen", {31'h0, frame_done}, 32'h1);
        digit   = 4'hF;
        display = 7'h7F;
        repeat (63) @(negedge clk);
        chk("t5_valid_63", {31'h0, valid}, 32'h1);
        @(negedge clk);
        chk("t5_valid_64", {31'h0, valid}, 32'h0);
        repeat (6) @(negedge clk);
        chk("t5_nums_hold", {16'h0, nums}, 32'h8642);
        chk("t4_err_sticky", {31'h0, err}, 32'h1);

        hold(dsel(0), enc(4'h8), 16);
        hold(dsel(1), enc(4'h7), 16);
        hold(dsel(2), enc(4'h6), 16);
        digit   = 4'hF;
        display = 7'h7F;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_nums", {16'h0, nums}, 32'h0);
        chk("t6_rst_err", {31'h0, err}, 32'h0);
        base = n_frames;
        sb_q.push_back(16'h5678);
        hold(dsel(3), enc(4'h5), 16);
        chk("t6_no_early", n_frames, base);
        hold(dsel(0), enc(4'h8), 16);
        hold(dsel(1), enc(4'h7), 16);
        hold(dsel(2), enc(4'h6), 16);
        hold(4'hF, 7'h7F, 8);
        chk("t6_frames", n_frames, base + 1);
        chk("t6_nums", {16'h0, nums}, 32'h5678);
        chk("t6_valid", {31'h0, valid}, 32'h1);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
